dly_load_seq: RTL and testbench

DLY_LOAD_SEQ -- requirements
Module: dly_load_seq

---
 rtl/dly_load_seq_pkg.sv | 22 ++
 rtl/dly_load_seq_table.sv | 70 +++++++
 rtl/dly_load_seq.sv | 131 +++++++++++++
 tb/tb_dly_load_seq.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dly_load_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dly_load_seq_pkg
// Description : Shared tap width and sequencer state encoding for the
//               delay-line load sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package dly_load_seq_pkg;

    localparam int DLY_WIDTH = 5;
    localparam int STATE_W   = 3;

    localparam logic [STATE_W-1:0] ST_IDLE   = 3'd0;
    localparam logic [STATE_W-1:0] ST_LOAD   = 3'd1;
    localparam logic [STATE_W-1:0] ST_SET    = 3'd2;
    localparam logic [STATE_W-1:0] ST_SETTLE = 3'd3;
    localparam logic [STATE_W-1:0] ST_FIN    = 3'd4;

    typedef logic [DLY_WIDTH-1:0] dly_t;

endpackage
`default_nettype wire

// File: rtl/dly_load_seq_table.sv
`default_nettype none
// ============================================================================
// Module      : dly_table
// Description : Per-lane staged/applied tap tables with single-lane write,
//               bulk staged-to-applied copy and registered readback.
// Revision    : 1.0 - initial release
// ============================================================================
module dly_table
    import dly_load_seq_pkg::*;
#(
    parameter int NUM_LANES = 8,
    parameter int LANE_BITS = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 wr_en,
    input  logic [LANE_BITS-1:0] wr_lane,
    input  logic [DLY_WIDTH-1:0] wr_data,
    input  logic                 copy_en,
    input  logic [LANE_BITS-1:0] rd_lane,
    output logic [DLY_WIDTH-1:0] rd_staged,
    output logic [DLY_WIDTH-1:0] rd_applied
);

    logic [DLY_WIDTH-1:0] r_staged   [NUM_LANES];
    logic [DLY_WIDTH-1:0] r_applied  [NUM_LANES];
    logic [DLY_WIDTH-1:0] r_rd_staged;
    logic [DLY_WIDTH-1:0] r_rd_applied;
    logic [DLY_WIDTH-1:0] w_rd_staged;
    logic [DLY_WIDTH-1:0] w_rd_applied;

    // Lane selects beyond the table match no entry and read back as zero.
    always_comb begin
        w_rd_staged  = '0;
        w_rd_applied = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (rd_lane == LANE_BITS'(i)) begin
                w_rd_staged  = r_staged[i];
                w_rd_applied = r_applied[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_LANES; i++) begin
                r_staged[i]  <= '0;
                r_applied[i] <= '0;
            end
            r_rd_staged  <= '0;
            r_rd_applied <= '0;
        end else begin
            for (int i = 0; i < NUM_LANES; i++) begin
                if (copy_en) begin
                    r_applied[i] <= r_staged[i];
                end
                if (wr_en && (wr_lane == LANE_BITS'(i))) begin
                    r_staged[i] <= wr_data;
                end
            end
            r_rd_staged  <= w_rd_staged;
            r_rd_applied <= w_rd_applied;
        end
    end

    assign rd_staged  = r_rd_staged;
    assign rd_applied = r_rd_applied;

endmodule
`default_nettype wire

// File: rtl/dly_load_seq.sv
`default_nettype none
// ============================================================================
// Module      : dly_load_seq
// Description : Sequences per-lane delay-tap loads and a common transfer
//               strobe, then waits for the delay lines to settle.
// Revision    : 1.0 - initial release
// ============================================================================
module dly_load_seq
    import dly_load_seq_pkg::*;
#(
    parameter int NUM_LANES     = 8,
    parameter int LANE_BITS     = 3,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [LANE_BITS-1:0] cmd_lane,
    input  logic [DLY_WIDTH-1:0] cmd_delay,
    input  logic                 cmd_apply,
    output logic [DLY_WIDTH-1:0] dly_val,
    output logic [NUM_LANES-1:0] dly_ld,
    output logic                 dly_set,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    input  logic [LANE_BITS-1:0] rd_lane,
    output logic [DLY_WIDTH-1:0] rd_staged,
    output logic [DLY_WIDTH-1:0] rd_applied
);

    localparam int                   c_cnt_w     = $clog2(SETTLE_CYCLES + 1);
    localparam logic [c_cnt_w-1:0]   c_settle    = c_cnt_w'(SETTLE_CYCLES);
    localparam logic [LANE_BITS:0]   c_num_lanes = (LANE_BITS + 1)'(NUM_LANES);

    logic [STATE_W-1:0]   r_state;
    logic [STATE_W-1:0]   w_state_nxt;
    logic [LANE_BITS-1:0] r_lane;
    logic                 r_apply;
    logic                 r_lane_ok;
    logic [c_cnt_w-1:0]   r_cnt;
    logic [DLY_WIDTH-1:0] r_dly_val;
    logic [NUM_LANES-1:0] r_dly_ld;
    logic                 r_dly_set;
    logic                 r_done;
    logic                 r_err;
    logic                 w_hs;
    logic                 w_cmd_ok;
    logic [NUM_LANES-1:0] w_onehot;

    assign cmd_ready = (r_state == ST_IDLE);
    assign w_hs      = cmd_valid & cmd_ready;
    assign w_cmd_ok  = ({1'b0, cmd_lane} < c_num_lanes);
    assign w_onehot  = NUM_LANES'(1) << cmd_lane;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:   if (w_hs) w_state_nxt = ST_LOAD;
            ST_LOAD:   w_state_nxt = (r_apply && r_lane_ok) ? ST_SET : ST_FIN;
            ST_SET:    w_state_nxt = ST_SETTLE;
            ST_SETTLE: if (r_cnt <= c_cnt_w'(1)) w_state_nxt = ST_FIN;
            ST_FIN:    w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    // Strobes are decoded from the next state so they are flop outputs that
    // line up exactly with the state they belong to.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_lane    <= '0;
            r_apply   <= 1'b0;
            r_lane_ok <= 1'b0;
            r_cnt     <= '0;
            r_dly_val <= '0;
            r_dly_ld  <= '0;
            r_dly_set <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_dly_ld  <= '0;
            r_err     <= 1'b0;
            r_dly_set <= (w_state_nxt == ST_SET);
            r_done    <= (w_state_nxt == ST_FIN);
            if (w_hs) begin
                r_lane    <= cmd_lane;
                r_apply   <= cmd_apply;
                r_lane_ok <= w_cmd_ok;
                if (w_cmd_ok) begin
                    r_dly_ld  <= w_onehot;
                    r_dly_val <= cmd_delay;
                end else begin
                    r_err <= 1'b1;
                end
            end
            if (r_state == ST_SET) begin
                r_cnt <= c_settle;
            end else if (r_state == ST_SETTLE) begin
                r_cnt <= r_cnt - c_cnt_w'(1);
            end
        end
    end

    dly_table #(
        .NUM_LANES (NUM_LANES),
        .LANE_BITS (LANE_BITS)
    ) u_table (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_en      ((r_state == ST_LOAD) && r_lane_ok),
        .wr_lane    (r_lane),
        .wr_data    (r_dly_val),
        .copy_en    (r_state == ST_SET),
        .rd_lane    (rd_lane),
        .rd_staged  (rd_staged),
        .rd_applied (rd_applied)
    );

    assign dly_val = r_dly_val;
    assign dly_ld  = r_dly_ld;
    assign dly_set = r_dly_set;
    assign done    = r_done;
    assign err     = r_err;
    assign busy    = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_dly_load_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_dly_load_seq
// Description : Scoreboard bench for dly_load_seq: stimulus queues expected
//               strobes, a negedge monitor pops and compares them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dly_load_seq;

    localparam int NUM_LANES     = 8;
    localparam int LANE_BITS     = 4;
    localparam int SETTLE_CYCLES = 4;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 cmd_valid = 1'b0;
    logic                 cmd_ready;
    logic [LANE_BITS-1:0] cmd_lane = '0;
    logic [4:0]           cmd_delay = '0;
    logic                 cmd_apply = 1'b0;
    logic [4:0]           dly_val;
    logic [NUM_LANES-1:0] dly_ld;
    logic                 dly_set;
    logic                 busy;
    logic                 done;
    logic                 err;
    logic [LANE_BITS-1:0] rd_lane = '0;
    logic [4:0]           rd_staged;
    logic [4:0]           rd_applied;

    dly_load_seq #(
        .NUM_LANES     (NUM_LANES),
        .LANE_BITS     (LANE_BITS),
        .SETTLE_CYCLES (SETTLE_CYCLES)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_lane   (cmd_lane),
        .cmd_delay  (cmd_delay),
        .cmd_apply  (cmd_apply),
        .dly_val    (dly_val),
        .dly_ld     (dly_ld),
        .dly_set    (dly_set),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .rd_lane    (rd_lane),
        .rd_staged  (rd_staged),
        .rd_applied (rd_applied)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int cyc;
        int ld;
        int val;
    } ev_t;

    ev_t q_ld[$];
    ev_t q_err[$];
    ev_t q_set[$];
    ev_t q_done[$];

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic miss(input string name, input int exp_cyc);
        n_chk++;
        n_err++;
        $display("FAIL %s: event cycle %0d, now cycle %0d", name, exp_cyc, cyc);
    endtask

    always @(negedge clk) begin
        ev_t e;
        if (rst_n) begin
            if (q_ld.size() != 0 && q_ld[0].cyc < cyc) begin
                miss("dly_ld missing", q_ld[0].cyc);
                void'(q_ld.pop_front());
            end
            if (q_err.size() != 0 && q_err[0].cyc < cyc) begin
                miss("err missing", q_err[0].cyc);
                void'(q_err.pop_front());
            end
            if (q_set.size() != 0 && q_set[0].cyc < cyc) begin
                miss("dly_set missing", q_set[0].cyc);
                void'(q_set.pop_front());
            end
            if (q_done.size() != 0 && q_done[0].cyc < cyc) begin
                miss("done missing", q_done[0].cyc);
                void'(q_done.pop_front());
            end
            if (dly_ld != '0) begin
                if (q_ld.size() == 0) miss("dly_ld unexpected", cyc);
                else begin
                    e = q_ld.pop_front();
                    chk("ld_cycle", cyc, e.cyc);
                    chk("ld_mask", 32'(dly_ld), e.ld);
                    chk("ld_val", 32'(dly_val), e.val);
                end
            end
            if (err) begin
                if (q_err.size() == 0) miss("err unexpected", cyc);
                else begin
                    e = q_err.pop_front();
                    chk("err_cycle", cyc, e.cyc);
                end
            end
            if (dly_set) begin
                if (q_set.size() == 0) miss("dly_set unexpected", cyc);
                else begin
                    e = q_set.pop_front();
                    chk("set_cycle", cyc, e.cyc);
                end
            end
            if (done) begin
                if (q_done.size() == 0) miss("done unexpected", cyc);
                else begin
                    e = q_done.pop_front();
                    chk("done_cycle", cyc, e.cyc);
                end
            end
        end
    end

    // Called at a negedge; returns at the negedge of the LOAD cycle (T+1).
    task automatic issue(input int lane, input int dly, input bit apply, input bit hold,
                         output int t, output int rdy);
        bit ok;
        int n;
        ok = (lane < NUM_LANES);
        n  = 0;
        while (!cmd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) miss("cmd_ready timeout", cyc);
        cmd_valid = 1'b1;
        cmd_lane  = LANE_BITS'(lane);
        cmd_delay = 5'(dly);
        cmd_apply = apply;
        t = cyc;
        if (ok) q_ld.push_back('{t + 1, 1 << lane, dly});
        else    q_err.push_back('{t + 1, 0, 0});
        if (ok && apply) begin
            q_set.push_back('{t + 2, 0, 0});
            q_done.push_back('{t + 3 + SETTLE_CYCLES, 0, 0});
            rdy = t + 4 + SETTLE_CYCLES;
        end else begin
            q_done.push_back('{t + 2, 0, 0});
            rdy = t + 3;
        end
        @(negedge clk);
        if (!hold) cmd_valid = 1'b0;
    endtask

    task automatic finish_cmd(input int rdy, input bit hold);
        while (cyc < rdy) begin
            chk("cmd_ready_busy", 32'(cmd_ready), 0);
            if (hold) begin
                cmd_lane  = (cyc % 2 != 0) ? LANE_BITS'(4) : LANE_BITS'(6);
                cmd_delay = 5'(cyc % 32);
                cmd_apply = 1'b1;
            end
            @(negedge clk);
        end
        chk("cmd_ready_idle", 32'(cmd_ready), 1);
        cmd_valid = 1'b0;
    endtask

    task automatic check_rd(input int lane, input int es, input int ea);
        rd_lane = LANE_BITS'(lane);
        @(negedge clk);
        chk($sformatf("rd_staged[%0d]", lane), 32'(rd_staged), es);
        chk($sformatf("rd_applied[%0d]", lane), 32'(rd_applied), ea);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_dly_val"}, 32'(dly_val), 0);
        chk({tag, "_dly_ld"}, 32'(dly_ld), 0);
        chk({tag, "_dly_set"}, 32'(dly_set), 0);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_err"}, 32'(err), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_rd_staged"}, 32'(rd_staged), 0);
        chk({tag, "_rd_applied"}, 32'(rd_applied), 0);
        chk({tag, "_cmd_ready"}, 32'(cmd_ready), 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int t, rdy;

        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_reset", 32'(cmd_ready), 1);

        // Stage only: lane 2 <= 17, no transfer.
        issue(2, 17, 1'b0, 1'b0, t, rdy);
        finish_cmd(rdy, 1'b0);
        check_rd(2, 17, 0);

        // Stage and apply lane 5 <= 9; readback of lane 5 around its write.
        issue(5, 9, 1'b1, 1'b0, t, rdy);
        rd_lane = LANE_BITS'(5);
        @(negedge clk);
        chk("rd_pre_write_staged", 32'(rd_staged), 0);
        chk("rd_pre_write_applied", 32'(rd_applied), 0);
        @(negedge clk);
        chk("rd_post_write_staged", 32'(rd_staged), 9);
        chk("rd_pre_copy_applied", 32'(rd_applied), 0);
        @(negedge clk);
        chk("rd_post_copy_applied", 32'(rd_applied), 9);
        finish_cmd(rdy, 1'b0);
        check_rd(2, 17, 17);
        check_rd(5, 9, 9);

        // Out-of-range lane with apply: error only, tables untouched.
        issue(9, 3, 1'b1, 1'b0, t, rdy);
        finish_cmd(rdy, 1'b0);
        chk("dly_val_held", 32'(dly_val), 9);
        check_rd(5, 9, 9);
        check_rd(2, 17, 17);
        check_rd(9, 0, 0);

        // cmd_valid held with changing payload while busy.
        issue(3, 12, 1'b1, 1'b1, t, rdy);
        finish_cmd(rdy, 1'b1);
        check_rd(3, 12, 12);
        check_rd(4, 0, 0);
        check_rd(6, 0, 0);

        // Reset during SETTLE aborts the command.
        rd_lane = LANE_BITS'(3);
        issue(1, 7, 1'b1, 1'b0, t, rdy);
        while (cyc < t + 4) @(negedge clk);
        @(posedge clk);
        #2;
        q_ld.delete();
        q_err.delete();
        q_set.delete();
        q_done.delete();
        rst_n = 1'b0;
        #1;
        chk_all_zero("mid_reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_abort", 32'(cmd_ready), 1);
        check_rd(1, 0, 0);
        check_rd(2, 0, 0);
        check_rd(3, 0, 0);
        check_rd(5, 0, 0);
        repeat (10) @(negedge clk);

        // Apply lane 0 from a fresh reset, then an erroring apply.
        issue(0, 31, 1'b1, 1'b0, t, rdy);
        finish_cmd(rdy, 1'b0);
        issue(9, 5, 1'b1, 1'b0, t, rdy);
        finish_cmd(rdy, 1'b0);
        check_rd(0, 31, 31);
        chk("dly_val_after_err", 32'(dly_val), 31);

        repeat (5) @(negedge clk);
        chk("pending_events", q_ld.size() + q_err.size() + q_set.size() + q_done.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
`default_nettype wire
